// File: rtl/cpu_axi_arbiter.sv
// Two-to-one AXI3 arbiter merging CPU icache (port 0) and dcache (port 1) onto one master port.
// Define CPU_AXI_ARB_DCACHE_PRIO_EN for fixed dcache priority; default is per-path round-robin.
module cpu_axi_arbiter #(
  parameter int BUS_WIDTH = 4
) (
  input  logic                 aclk,
  input  logic                 reset,
  // slave port 0 (icache)
  input  logic [BUS_WIDTH-1:0] s0_arid,
  input  logic [31:0]          s0_araddr,
  input  logic [3:0]           s0_arlen, s0_arcache,
  input  logic [2:0]           s0_arsize, s0_arprot,
  input  logic [1:0]           s0_arburst, s0_arlock,
  input  logic                 s0_arvalid,
  output logic                 s0_arready,
  output logic [BUS_WIDTH-1:0] s0_rid,
  output logic [31:0]          s0_rdata,
  output logic [1:0]           s0_rresp,
  output logic                 s0_rlast, s0_rvalid,
  input  logic                 s0_rready,
  input  logic [BUS_WIDTH-1:0] s0_awid,
  input  logic [31:0]          s0_awaddr,
  input  logic [3:0]           s0_awlen, s0_awcache,
  input  logic [2:0]           s0_awsize, s0_awprot,
  input  logic [1:0]           s0_awburst, s0_awlock,
  input  logic                 s0_awvalid,
  output logic                 s0_awready,
  input  logic [BUS_WIDTH-1:0] s0_wid,
  input  logic [31:0]          s0_wdata,
  input  logic [3:0]           s0_wstrb,
  input  logic                 s0_wlast, s0_wvalid,
  output logic                 s0_wready,
  output logic [BUS_WIDTH-1:0] s0_bid,
  output logic [1:0]           s0_bresp,
  output logic                 s0_bvalid,
  input  logic                 s0_bready,
  // slave port 1 (dcache)
  input  logic [BUS_WIDTH-1:0] s1_arid,
  input  logic [31:0]          s1_araddr,
  input  logic [3:0]           s1_arlen, s1_arcache,
  input  logic [2:0]           s1_arsize, s1_arprot,
  input  logic [1:0]           s1_arburst, s1_arlock,
  input  logic                 s1_arvalid,
  output logic                 s1_arready,
  output logic [BUS_WIDTH-1:0] s1_rid,
  output logic [31:0]          s1_rdata,
  output logic [1:0]           s1_rresp,
  output logic                 s1_rlast, s1_rvalid,
  input  logic                 s1_rready,
  input  logic [BUS_WIDTH-1:0] s1_awid,
  input  logic [31:0]          s1_awaddr,
  input  logic [3:0]           s1_awlen, s1_awcache,
  input  logic [2:0]           s1_awsize, s1_awprot,
  input  logic [1:0]           s1_awburst, s1_awlock,
  input  logic                 s1_awvalid,
  output logic                 s1_awready,
  input  logic [BUS_WIDTH-1:0] s1_wid,
  input  logic [31:0]          s1_wdata,
  input  logic [3:0]           s1_wstrb,
  input  logic                 s1_wlast, s1_wvalid,
  output logic                 s1_wready,
  output logic [BUS_WIDTH-1:0] s1_bid,
  output logic [1:0]           s1_bresp,
  output logic                 s1_bvalid,
  input  logic                 s1_bready,
  // master port toward the interconnect
  output logic [BUS_WIDTH-1:0] m_arid,
  output logic [31:0]          m_araddr,
  output logic [3:0]           m_arlen, m_arcache,
  output logic [2:0]           m_arsize, m_arprot,
  output logic [1:0]           m_arburst, m_arlock,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [BUS_WIDTH-1:0] m_rid,
  input  logic [31:0]          m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast, m_rvalid,
  output logic                 m_rready,
  output logic [BUS_WIDTH-1:0] m_awid,
  output logic [31:0]          m_awaddr,
  output logic [3:0]           m_awlen, m_awcache,
  output logic [2:0]           m_awsize, m_awprot,
  output logic [1:0]           m_awburst, m_awlock,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [BUS_WIDTH-1:0] m_wid,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic                 m_wlast, m_wvalid,
  input  logic                 m_wready,
  input  logic [BUS_WIDTH-1:0] m_bid,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic      rd_grant, rd_grant_next, rd_pick;
  logic      wr_grant, wr_grant_next, wr_pick;
  logic      rd_req, wr_req;

  assign rd_req = s0_arvalid | s1_arvalid;
  assign wr_req = s0_awvalid | s1_awvalid;

`ifdef CPU_AXI_ARB_DCACHE_PRIO_EN
  assign rd_pick = s1_arvalid;
  assign wr_pick = s1_awvalid;
`else
  // Pointer names the port that wins the next tie; it flips away from every granted port.
  logic rd_prio, wr_prio;
  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_prio <= 1'b1;
      wr_prio <= 1'b1;
    end else begin
      if (rd_state == R_IDLE && rd_req) rd_prio <= ~rd_pick;
      if (wr_state == W_IDLE && wr_req) wr_prio <= ~wr_pick;
    end
  end
  assign rd_pick = (s0_arvalid & s1_arvalid) ? rd_prio : s1_arvalid;
  assign wr_pick = (s0_awvalid & s1_awvalid) ? wr_prio : s1_awvalid;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_grant <= 1'b0;
      wr_state <= W_IDLE;
      wr_grant <= 1'b0;
    end else begin
      rd_state <= rd_next;
      rd_grant <= rd_grant_next;
      wr_state <= wr_next;
      wr_grant <= wr_grant_next;
    end
  end

  // NOTE: defaults assigned first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    rd_next       = rd_state;
    rd_grant_next = rd_grant;
    case (rd_state)
      R_IDLE: if (rd_req) begin
        rd_next       = R_ADDR;
        rd_grant_next = rd_pick;
      end
      R_ADDR:  if (m_arvalid & m_arready) rd_next = R_DATA;
      R_DATA:  if (m_rvalid & m_rready & m_rlast) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next       = wr_state;
    wr_grant_next = wr_grant;
    case (wr_state)
      W_IDLE: if (wr_req) begin
        wr_next       = W_ADDR;
        wr_grant_next = wr_pick;
      end
      W_ADDR:  if (m_awvalid & m_awready) wr_next = W_DATA;
      W_DATA:  if (m_wvalid & m_wready & m_wlast) wr_next = W_RESP;
      W_RESP:  if (m_bvalid & m_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Read path: handshakes are gated by registered state, so nothing is visible in R_IDLE.
  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot} = rd_grant
    ? {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot}
    : {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot};
  assign m_arvalid  = (rd_state == R_ADDR) & (rd_grant ? s1_arvalid : s0_arvalid);
  assign s0_arready = (rd_state == R_ADDR) & ~rd_grant & m_arready;
  assign s1_arready = (rd_state == R_ADDR) &  rd_grant & m_arready;
  assign m_rready   = (rd_state == R_DATA) & (rd_grant ? s1_rready : s0_rready);
  assign s0_rvalid  = (rd_state == R_DATA) & ~rd_grant & m_rvalid;
  assign s1_rvalid  = (rd_state == R_DATA) &  rd_grant & m_rvalid;
  assign {s0_rid, s0_rdata, s0_rresp, s0_rlast} = {m_rid, m_rdata, m_rresp, m_rlast};
  assign {s1_rid, s1_rdata, s1_rresp, s1_rlast} = {m_rid, m_rdata, m_rresp, m_rlast};

  // Write path: W is only forwarded in W_DATA, i.e. strictly after the AW handshake.
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot} = wr_grant
    ? {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot}
    : {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot};
  assign {m_wid, m_wdata, m_wstrb, m_wlast} = wr_grant ? {s1_wid, s1_wdata, s1_wstrb, s1_wlast}
                                                       : {s0_wid, s0_wdata, s0_wstrb, s0_wlast};
  assign m_awvalid  = (wr_state == W_ADDR) & (wr_grant ? s1_awvalid : s0_awvalid);
  assign s0_awready = (wr_state == W_ADDR) & ~wr_grant & m_awready;
  assign s1_awready = (wr_state == W_ADDR) &  wr_grant & m_awready;
  assign m_wvalid   = (wr_state == W_DATA) & (wr_grant ? s1_wvalid : s0_wvalid);
  assign s0_wready  = (wr_state == W_DATA) & ~wr_grant & m_wready;
  assign s1_wready  = (wr_state == W_DATA) &  wr_grant & m_wready;
  assign m_bready   = (wr_state == W_RESP) & (wr_grant ? s1_bready : s0_bready);
  assign s0_bvalid  = (wr_state == W_RESP) & ~wr_grant & m_bvalid;
  assign s1_bvalid  = (wr_state == W_RESP) &  wr_grant & m_bvalid;
  assign {s0_bid, s0_bresp} = {m_bid, m_bresp};
  assign {s1_bid, s1_bresp} = {m_bid, m_bresp};

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Directed self-checking bench for cpu_axi_arbiter (default round-robin build).
module tb_cpu_axi_arbiter;
  localparam int BW = 4;

  logic aclk = 1'b0, reset;
  logic [BW-1:0] s0_arid, s0_rid, s0_awid, s0_wid, s0_bid;
  logic [31:0]   s0_araddr, s0_rdata, s0_awaddr, s0_wdata;
  logic [3:0]    s0_arlen, s0_arcache, s0_awlen, s0_awcache, s0_wstrb;
  logic [2:0]    s0_arsize, s0_arprot, s0_awsize, s0_awprot;
  logic [1:0]    s0_arburst, s0_arlock, s0_awburst, s0_awlock, s0_rresp, s0_bresp;
  logic          s0_arvalid, s0_arready, s0_rlast, s0_rvalid, s0_rready, s0_awvalid, s0_awready;
  logic          s0_wlast, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic [BW-1:0] s1_arid, s1_rid, s1_awid, s1_wid, s1_bid;
  logic [31:0]   s1_araddr, s1_rdata, s1_awaddr, s1_wdata;
  logic [3:0]    s1_arlen, s1_arcache, s1_awlen, s1_awcache, s1_wstrb;
  logic [2:0]    s1_arsize, s1_arprot, s1_awsize, s1_awprot;
  logic [1:0]    s1_arburst, s1_arlock, s1_awburst, s1_awlock, s1_rresp, s1_bresp;
  logic          s1_arvalid, s1_arready, s1_rlast, s1_rvalid, s1_rready, s1_awvalid, s1_awready;
  logic          s1_wlast, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic [BW-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [31:0]   m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [3:0]    m_arlen, m_arcache, m_awlen, m_awcache, m_wstrb;
  logic [2:0]    m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]    m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
  logic          m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, m_awvalid, m_awready;
  logic          m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;

  cpu_axi_arbiter #(.BUS_WIDTH(BW)) dut (
    .aclk(aclk), .reset(reset),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arcache(s0_arcache),
    .s0_arsize(s0_arsize), .s0_arprot(s0_arprot), .s0_arburst(s0_arburst), .s0_arlock(s0_arlock),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awcache(s0_awcache),
    .s0_awsize(s0_awsize), .s0_awprot(s0_awprot), .s0_awburst(s0_awburst), .s0_awlock(s0_awlock),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_wid(s0_wid), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arcache(s1_arcache),
    .s1_arsize(s1_arsize), .s1_arprot(s1_arprot), .s1_arburst(s1_arburst), .s1_arlock(s1_arlock),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awcache(s1_awcache),
    .s1_awsize(s1_awsize), .s1_awprot(s1_awprot), .s1_awburst(s1_awburst), .s1_awlock(s1_awlock),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_wid(s1_wid), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arcache(m_arcache),
    .m_arsize(m_arsize), .m_arprot(m_arprot), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awcache(m_awcache),
    .m_awsize(m_awsize), .m_awprot(m_awprot), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] hs_vec();
    return {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s0_arready, s1_arready,
            s0_awready, s1_awready, s0_wready, s1_wready, s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid};
  endfunction

  // One read while both ports keep requesting; exp_port is the port that must win.
  task automatic rd_one(input logic exp_port, input string tag);
    tick();
    check({tag, "_addr"}, m_araddr, exp_port ? 32'h2000_0000 : 32'h1000_0000);
    check({tag, "_arready"}, {s1_arready, s0_arready}, exp_port ? 2'b10 : 2'b01);
    tick();
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    check({tag, "_rvalid"}, {s1_rvalid, s0_rvalid}, exp_port ? 2'b10 : 2'b01);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {s0_arid, s0_araddr, s0_arlen, s0_arcache, s0_arsize, s0_arprot, s0_arburst, s0_arlock, s0_arvalid, s0_rready} = '0;
    {s0_awid, s0_awaddr, s0_awlen, s0_awcache, s0_awsize, s0_awprot, s0_awburst, s0_awlock, s0_awvalid} = '0;
    {s0_wid, s0_wdata, s0_wstrb, s0_wlast, s0_wvalid, s0_bready} = '0;
    {s1_arid, s1_araddr, s1_arlen, s1_arcache, s1_arsize, s1_arprot, s1_arburst, s1_arlock, s1_arvalid, s1_rready} = '0;
    {s1_awid, s1_awaddr, s1_awlen, s1_awcache, s1_awsize, s1_awprot, s1_awburst, s1_awlock, s1_awvalid} = '0;
    {s1_wid, s1_wdata, s1_wstrb, s1_wlast, s1_wvalid, s1_bready} = '0;
    {m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, m_awready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
    tick(); tick();
    check("reset_outputs", hs_vec(), 15'h0);
    reset = 1'b0;

    // Round-robin: both ports request continuously, pointer starts on port 1.
    s0_araddr = 32'h1000_0000; s1_araddr = 32'h2000_0000;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1; m_arready = 1'b1;
    rd_one(1'b1, "rr0");
    rd_one(1'b0, "rr1");
    rd_one(1'b1, "rr2");
    rd_one(1'b0, "rr3");
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_arready = 1'b0;
    tick();

    // Single s0 burst with a stalled address channel and a competing s1 request.
    s0_araddr = 32'h1FC0_0000; s0_arlen = 4'd7; s0_arid = 4'h3; s0_arsize = 3'd2; s0_arburst = 2'b01;
    s0_arvalid = 1'b1;
    #1;
    check("ar_idle_latency", m_arvalid, 1'b0);
    tick();
    check("ar_valid", m_arvalid, 1'b1);
    check("ar_payload", {m_arid, m_arlen, m_arsize, m_arburst}, {4'h3, 4'd7, 3'd2, 2'b01});
    s1_araddr = 32'h2000_0040; s1_arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ar_stall_addr", m_araddr, 32'h1FC0_0000);
      check("ar_stall_ready", {m_arvalid, s1_arready, s0_arready}, 3'b100);
    end
    m_arready = 1'b1;
    #1;
    check("ar_handshake", {s1_arready, s0_arready}, 2'b01);
    tick();
    s0_arvalid = 1'b0; m_arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1; m_rid = 4'h3; m_rdata = 32'hD000_0000 + 32'(i); m_rlast = (i == 7);
      #1;
      check("r_route", {s1_rvalid, s0_rvalid, m_rready}, 3'b011);
      check("r_data", s0_rdata, 32'hD000_0000 + 32'(i));
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    check("r_idle_after_last", {m_rready, m_arvalid}, 2'b00);
    tick();
    check("s1_waited_addr", m_araddr, 32'h2000_0040);
    m_arready = 1'b1;
    #1;
    check("s1_arready", {s1_arready, s0_arready}, 2'b10);
    tick();
    s1_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    check("s1_rvalid", {s1_rvalid, s0_rvalid}, 2'b10);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // s1 write with W offered before AW.
    s1_wvalid = 1'b1; s1_wdata = 32'hCAFE_0000; s1_wstrb = 4'hF; m_wready = 1'b1; m_awready = 1'b1;
    #1;
    check("w_before_aw", {s1_wready, m_wvalid}, 2'b00);
    s1_awvalid = 1'b1; s1_awaddr = 32'h8000_1000; s1_awlen = 4'd3; s1_awid = 4'h5;
    #1;
    check("aw_idle_latency", m_awvalid, 1'b0);
    tick();
    check("aw_fwd", {m_awvalid, s1_awready, s0_awready, s1_wready, m_wvalid}, 5'b11000);
    check("aw_payload", {m_awaddr, m_awlen, m_awid}, {32'h8000_1000, 4'd3, 4'h5});
    tick();
    s1_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s1_wdata = 32'hCAFE_0000 + 32'(i); s1_wlast = (i == 3);
      #1;
      check("w_route", {s1_wready, s0_wready, m_wvalid, m_wlast}, {3'b101, i == 3});
      check("w_data", {m_wdata, m_wstrb}, {32'hCAFE_0000 + 32'(i), 4'hF});
      tick();
    end
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00; m_bid = 4'h5; s1_bready = 1'b1; s0_bready = 1'b1;
    #1;
    check("b_route", {s1_bvalid, s0_bvalid, m_bready}, 3'b101);
    check("b_payload", {s1_bid, s1_bresp}, {4'h5, 2'b00});
    tick();
    m_bvalid = 1'b0;
    #1;
    check("w_idle_after_b", m_bready, 1'b0);

    // Concurrent s0 read and s1 write.
    s0_araddr = 32'h1000_0100; s0_arlen = 4'd1; s0_arvalid = 1'b1; m_arready = 1'b1;
    s1_awaddr = 32'h8000_2000; s1_awlen = 4'd0; s1_awvalid = 1'b1;
    tick();
    check("conc_addr", {m_arvalid, m_awvalid, s0_arready, s1_awready}, 4'b1111);
    tick();
    s0_arvalid = 1'b0; s1_awvalid = 1'b0; m_arready = 1'b0;
    s1_wvalid = 1'b1; s1_wlast = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b0;
    #1;
    check("conc_beat1", {s0_rvalid, s1_rvalid, s1_wready, s0_wready}, 4'b1010);
    tick();
    s1_wvalid = 1'b0; s1_wlast = 1'b0; m_rlast = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b10;
    #1;
    check("conc_beat2", {s0_rvalid, s1_rvalid, s1_bvalid, s0_bvalid}, 4'b1010);
    check("conc_bresp", s1_bresp, 2'b10);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
    #1;
    check("conc_idle", hs_vec(), 15'h0);

    // Reset in the middle of an 8-beat s0 burst.
    s0_araddr = 32'h1FC0_0000; s0_arlen = 4'd7; s0_arvalid = 1'b1; m_arready = 1'b1;
    tick();
    tick();
    s0_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("mid_burst_reset", hs_vec(), 15'h0);
    reset = 1'b0; m_rvalid = 1'b0;
    s0_arlen = 4'd0; s0_arvalid = 1'b1; m_arready = 1'b1;
    tick();
    check("post_reset_grant", {m_arvalid, s0_arready, s1_arready}, 3'b110);
    tick();
    s0_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h0BAD_F00D;
    #1;
    check("post_reset_rdata", {s0_rvalid, s1_rvalid, s0_rdata}, {2'b10, 32'h0BAD_F00D});
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    check("post_reset_idle", hs_vec(), 15'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
